// File: rtl/calc1_port_responder.sv
// calc1 single-port responder: two-cycle request capture, response pulse LATENCY cycles after operand2.
// Requests arriving while busy are dropped; CALC1_SHIFT_EN enables the shl/shr commands (5/6).
module calc1_port_responder #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    OP2,
    EXEC,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cmd;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  cnt;

  logic [32:0] sum;
  logic [1:0]  res_resp;
  logic [31:0] res_data;

  always_comb begin
    sum      = {1'b0, op1} + {1'b0, op2};
    res_resp = 2'd3;
    res_data = 32'd0;
    case (cmd)
      4'd1: begin
        if (sum[32]) begin
          res_resp = 2'd2;
        end else begin
          res_resp = 2'd1;
          res_data = sum[31:0];
        end
      end
      4'd2: begin
        if (op2 > op1) begin
          res_resp = 2'd2;
        end else begin
          res_resp = 2'd1;
          res_data = op1 - op2;
        end
      end
`ifdef CALC1_SHIFT_EN
      4'd5: begin
        res_resp = 2'd1;
        res_data = op1 << op2[4:0];
      end
      4'd6: begin
        res_resp = 2'd1;
        res_data = op1 >> op2[4:0];
      end
`endif
      default: begin
        res_resp = 2'd3;
        res_data = 32'd0;
      end
    endcase
  end

  // Result is registered on the EXEC->RESP edge so it is visible for the whole RESP cycle.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state    <= IDLE;
      cmd      <= 4'd0;
      op1      <= 32'd0;
      op2      <= 32'd0;
      cnt      <= 4'd0;
      out_resp <= 2'd0;
      out_data <= 32'd0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_resp <= 2'd0;
          out_data <= 32'd0;
          if (req_cmd_in != 4'd0) begin
            cmd   <= req_cmd_in;
            op1   <= req_data_in;
            busy  <= 1'b1;
            state <= OP2;
          end
        end
        OP2: begin
          op2   <= req_data_in;
          cnt   <= 4'(LATENCY - 1);
          state <= EXEC;
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            out_resp <= res_resp;
            out_data <= res_data;
            state    <= RESP;
          end
        end
        RESP: begin
          out_resp <= 2'd0;
          out_data <= 32'd0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
